// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared state encoding, LFSR taps and mole/level helpers.
// Revision : 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTART = 2'd1,
        ST_PLAY    = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [1:0] MAX_LEVEL = 2'd3;

    // The mole must always move, so a repeated candidate steps to the next hole.
    function automatic logic [2:0] next_mole(input logic [2:0] cand, input logic [2:0] cur);
        return (cand == cur) ? cur + 3'd1 : cand;
    endfunction

    function automatic logic [1:0] level_of(input logic [7:0] score);
        logic [7:0] sh;
        sh = score >> 3;
        return (sh > 8'(MAX_LEVEL)) ? MAX_LEVEL : sh[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_controller_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : mole_lfsr
// Purpose  : Free-running 8-bit Fibonacci LFSR used for mole placement.
// Revision : 1.0
// ============================================================================
module mole_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Bit 7 is a tap, so the map is invertible and a nonzero seed never reaches 0.
    assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_controller
// Purpose  : Whack-a-mole sequencer: game lifecycle, countdown, mole timing.
// Revision : 1.0
// ============================================================================
module game_controller
    import game_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 100000000,
    parameter int unsigned GAME_SECONDS = 30,
    parameter int unsigned MOLE_CYCLES  = 50000000,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       guess_correct,
    input  logic [7:0] score,
    output logic [2:0] mole_pos,
    output logic       mole_change,
    output logic       restart_game,
    output logic       game_over,
    output logic [7:0] time_left,
    output logic [1:0] level
);

    localparam int unsigned TW = $clog2(TICK_CYCLES + 1);
    localparam int unsigned DW = $clog2(MOLE_CYCLES + 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] c_MOLE      = DW'(MOLE_CYCLES);
    localparam logic [7:0]    c_GAME      = 8'(GAME_SECONDS);

    state_t        state_q;
    logic [2:0]    mole_pos_q;
    logic          mole_change_q;
    logic          restart_q;
    logic          game_over_q;
    logic [7:0]    time_left_q;
    logic [1:0]    level_q;
    logic [TW-1:0] tick_q;
    logic [DW-1:0] dwell_q;

    logic [7:0]    w_lfsr;
    logic          w_lfsr_unused;
    logic [1:0]    w_level;
    logic [DW-1:0] w_limit;
    logic          w_tick_wrap;
    logic          w_dwell_exp;
    logic [2:0]    w_new_mole;

    mole_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[7:3];
    assign w_new_mole    = next_mole(w_lfsr[2:0], mole_pos_q);
    // Level follows the live score so a mid-dwell level change shortens the current dwell.
    assign w_level       = level_of(score);
    assign w_limit       = c_MOLE >> w_level;
    assign w_tick_wrap   = (tick_q == c_TICK_LAST);
    assign w_dwell_exp   = ({1'b0, dwell_q} + (DW + 1)'(1)) >= {1'b0, w_limit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mole_pos_q    <= 3'd0;
            mole_change_q <= 1'b0;
            restart_q     <= 1'b0;
            game_over_q   <= 1'b1;
            time_left_q   <= c_GAME;
            level_q       <= 2'd0;
            tick_q        <= '0;
            dwell_q       <= '0;
        end else begin
            mole_change_q <= 1'b0;
            restart_q     <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (btn_start) begin
                        state_q   <= ST_RESTART;
                        restart_q <= 1'b1;
                    end
                end
                ST_RESTART: begin
                    state_q       <= ST_PLAY;
                    game_over_q   <= 1'b0;
                    time_left_q   <= c_GAME;
                    level_q       <= 2'd0;
                    tick_q        <= '0;
                    dwell_q       <= '0;
                    mole_pos_q    <= w_new_mole;
                    mole_change_q <= 1'b1;
                end
                ST_PLAY: begin
                    level_q <= w_level;
                    tick_q  <= w_tick_wrap ? '0 : tick_q + TW'(1);
                    // The final tick wins over any simultaneous mole event.
                    if (w_tick_wrap && (time_left_q == 8'd1)) begin
                        time_left_q <= 8'd0;
                        state_q     <= ST_OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        if (w_tick_wrap) begin
                            time_left_q <= time_left_q - 8'd1;
                        end
                        if (guess_correct || w_dwell_exp) begin
                            mole_pos_q    <= w_new_mole;
                            mole_change_q <= 1'b1;
                            dwell_q       <= '0;
                        end else begin
                            dwell_q <= dwell_q + DW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mole_pos     = mole_pos_q;
    assign mole_change  = mole_change_q;
    assign restart_game = restart_q;
    assign game_over    = game_over_q;
    assign time_left    = time_left_q;
    assign level        = level_q;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_controller
// Purpose  : Directed self-checking bench for game_controller.
// Revision : 1.0
// ============================================================================
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       guess_correct = 1'b0;
    logic [7:0] score = 8'd0;
    logic [2:0] mole_pos;
    logic       mole_change;
    logic       restart_game;
    logic       game_over;
    logic [7:0] time_left;
    logic [1:0] level;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    logic [2:0] exp_mole = 3'd0;

    game_controller #(
        .TICK_CYCLES  (10),
        .GAME_SECONDS (3),
        .MOLE_CYCLES  (16),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_start     (btn_start),
        .guess_correct (guess_correct),
        .score         (score),
        .mole_pos      (mole_pos),
        .mole_change   (mole_change),
        .restart_game  (restart_game),
        .game_over     (game_over),
        .time_left     (time_left),
        .level         (level)
    );

    always #5 clk = ~clk;

    // Reference LFSR: m_lfsr is the value during the current cycle, m_prev the previous one.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    function automatic logic [2:0] nm(input logic [2:0] cand, input logic [2:0] cur);
        logic [2:0] inc;
        inc = cur + 3'd1;
        return (cand == cur) ? inc : cand;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {game_over, time_left, mole_pos, mole_change, restart_game, level}
    localparam logic [15:0] RESET_VEC = {1'b1, 8'd3, 3'd0, 1'b0, 1'b0, 2'd0};

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({game_over, time_left, mole_pos, mole_change, restart_game, level} !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold got %h expected %h",
                     {game_over, time_left, mole_pos, mole_change, restart_game, level}, RESET_VEC);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({game_over, time_left, mole_pos, mole_change, restart_game, level} !== RESET_VEC) begin
            errors++;
            $display("FAIL idle_after_reset got %h expected %h",
                     {game_over, time_left, mole_pos, mole_change, restart_game, level}, RESET_VEC);
        end
        exp_mole = 3'd0;
    endtask

    task automatic test_start();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        checks++;
        if ({restart_game, game_over, mole_change} !== 3'b110) begin
            errors++;
            $display("FAIL start_n1 got %b expected 110", {restart_game, game_over, mole_change});
        end
        tick();
        exp_mole = nm(m_prev[2:0], exp_mole);
        checks++;
        if ({restart_game, game_over, mole_change, time_left} !== {3'b001, 8'd3}) begin
            errors++;
            $display("FAIL start_n2 got %h expected %h",
                     {restart_game, game_over, mole_change, time_left}, {3'b001, 8'd3});
        end
        checks++;
        if (mole_pos !== exp_mole) begin
            errors++;
            $display("FAIL start_mole got %0d expected %0d", mole_pos, exp_mole);
        end
    endtask

    task automatic test_countdown();
        int play_cycles;
        logic [7:0] exp_t;
        play_cycles = 1;
        for (int p = 1; p <= 31; p++) begin
            tick();
            if (p == 16) exp_mole = nm(m_prev[2:0], exp_mole);
            exp_t = (p < 30) ? 8'(3 - p / 10) : 8'd0;
            checks++;
            if ({time_left, mole_change} !== {exp_t, (p == 16)}) begin
                errors++;
                $display("FAIL countdown p=%0d got t=%0d mc=%b expected t=%0d mc=%b",
                         p, time_left, mole_change, exp_t, (p == 16));
            end
            if (game_over === 1'b0) play_cycles++;
        end
        checks++;
        if (play_cycles != 30) begin
            errors++;
            $display("FAIL play_cycles got %0d expected 30", play_cycles);
        end
        checks++;
        if (mole_pos !== exp_mole) begin
            errors++;
            $display("FAIL countdown_mole got %0d expected %0d", mole_pos, exp_mole);
        end
    endtask

    // Scenarios: score before/after switch, switch cycle, guess cycle, btn cycle,
    // hand-derived mole_change cycle mask over PLAY cycles 0..30, final level.
    task automatic test_dwell_level();
        logic [7:0]  sc0 [7] = '{8'd0, 8'd8, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [7:0]  sc1 [7] = '{8'd0, 8'd8, 8'd30, 8'd8, 8'd0, 8'd0, 8'd0};
        int          swp [7] = '{-1, -1, -1, 12, -1, -1, -1};
        int          gp  [7] = '{-1, -1, -1, -1, 5, 15, 29};
        int          bp  [7] = '{-1, -1, -1, -1, -1, -1, 5};
        logic [31:0] mk  [7] = '{32'h0001_0001, 32'h0101_0101, 32'h1555_5555,
                                 32'h2020_2001, 32'h0040_0041, 32'h0001_0001, 32'h0001_0001};
        logic [1:0]  lv  [7] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
        logic [2:0]  old;
        logic [7:0]  exp_t;
        for (int s = 0; s < 7; s++) begin
            score = sc0[s];
            btn_start = 1'b1;
            tick();
            btn_start = 1'b0;
            checks++;
            if (restart_game !== 1'b1) begin
                errors++;
                $display("FAIL replay_restart s=%0d got %b expected 1", s, restart_game);
            end
            for (int p = 0; p <= 30; p++) begin
                tick();
                guess_correct = 1'b0;
                btn_start = 1'b0;
                if (mk[s][p]) begin
                    old = exp_mole;
                    exp_mole = nm(m_prev[2:0], exp_mole);
                    checks++;
                    if (mole_pos !== exp_mole || mole_pos === old) begin
                        errors++;
                        $display("FAIL new_mole s=%0d p=%0d got %0d expected %0d prev %0d",
                                 s, p, mole_pos, exp_mole, old);
                    end
                end
                exp_t = (p < 30) ? 8'(3 - p / 10) : 8'd0;
                checks++;
                if ({mole_change, restart_game, game_over, time_left} !==
                    {mk[s][p], 1'b0, (p == 30), exp_t}) begin
                    errors++;
                    $display("FAIL play s=%0d p=%0d got mc=%b rg=%b go=%b t=%0d expected mc=%b rg=0 go=%b t=%0d",
                             s, p, mole_change, restart_game, game_over, time_left,
                             mk[s][p], (p == 30), exp_t);
                end
                if (p == 30) begin
                    checks++;
                    if ({mole_pos, level} !== {exp_mole, lv[s]}) begin
                        errors++;
                        $display("FAIL over_hold s=%0d got pos=%0d lvl=%0d expected pos=%0d lvl=%0d",
                                 s, mole_pos, level, exp_mole, lv[s]);
                    end
                end
                if (p == swp[s]) score = sc1[s];
                if (p == gp[s])  guess_correct = 1'b1;
                if (p == bp[s])  btn_start = 1'b1;
            end
        end
        score = 8'd0;
    endtask

    // Hit exactly when the LFSR candidate equals the current mole, steering toward hole 7.
    task automatic test_move_rule();
        int         dw;
        bit         pend;
        bit         forced;
        bit         found_wrap;
        logic [2:0] old;
        logic [2:0] exp_inc;
        found_wrap = 1'b0;
        for (int g = 0; g < 40 && !found_wrap; g++) begin
            repeat ($urandom_range(0, 5)) tick();
            btn_start = 1'b1;
            tick();
            btn_start = 1'b0;
            tick();
            exp_mole = nm(m_prev[2:0], exp_mole);
            dw = 0;
            pend = 1'b0;
            forced = 1'b0;
            for (int p = 0; p < 30; p++) begin
                if (p > 0) begin
                    tick();
                    guess_correct = 1'b0;
                    if (pend) begin
                        old = exp_mole;
                        exp_mole = nm(m_prev[2:0], exp_mole);
                        dw = 0;
                        if (forced) begin
                            exp_inc = old + 3'd1;
                            checks++;
                            if (mole_change !== 1'b1 || mole_pos !== exp_inc) begin
                                errors++;
                                $display("FAIL move_rule prev=%0d got mc=%b pos=%0d expected mc=1 pos=%0d",
                                         old, mole_change, mole_pos, exp_inc);
                            end
                            if (old == 3'd7) found_wrap = 1'b1;
                        end
                    end else begin
                        dw++;
                    end
                end
                forced = (p < 29) && (m_lfsr[2:0] == exp_mole);
                guess_correct = (p < 29) && (forced || m_lfsr[2:0] == 3'd7);
                pend = (p < 29) && (guess_correct || dw == 15);
            end
            tick();
            guess_correct = 1'b0;
        end
        checks++;
        if (!found_wrap) begin
            errors++;
            $display("FAIL move_wrap_search got no 7->0 case expected one within 40 games");
        end
    endtask

    task automatic test_async_reset();
        score = 8'd30;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        repeat (13) tick();
        checks++;
        if ({level, game_over, time_left} !== {2'd3, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL pre_reset got lvl=%0d go=%b t=%0d expected lvl=3 go=0 t=2",
                     level, game_over, time_left);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({game_over, time_left, mole_pos, mole_change, restart_game, level} !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset got %h expected %h",
                     {game_over, time_left, mole_pos, mole_change, restart_game, level}, RESET_VEC);
        end
        tick();
        tick();
        rst = 1'b0;
        score = 8'd0;
        exp_mole = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({restart_game, game_over, mole_pos} !== {1'b0, 1'b1, 3'd0}) begin
                errors++;
                $display("FAIL post_reset i=%0d got rg=%b go=%b pos=%0d expected rg=0 go=1 pos=0",
                         i, restart_game, game_over, mole_pos);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_countdown();
        test_dwell_level();
        test_move_rule();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
